uart_rx: RTL

- UART receiver; sits directly downstream of the baud-rate generator and consumes its 16x-oversample receive tick (Rxclk_en).
- Synchronises the asynchronous serial input, detects and validates the start bit, and samples each bit at its centre.
- Presents the received byte with a sticky ready flag, cleared by a handshake from the consumer (the FPU command decoder).
- Flags framing errors and overruns.

---
 rtl/uart_rx_if.sv | 32 +++
 rtl/uart_rx.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_if.sv
// Receive-side bundle between the baud generator / serial line / consumer and uart_rx.
// The parity_err signal exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic                 clken;
    logic                 rx;
    logic                 rdy_clr;
    logic [DATA_BITS-1:0] data;
    logic                 rdy;
    logic                 frame_err;
    logic                 overrun;
`ifdef UART_RX_PARITY_EN
    logic                 parity_err;
`endif

    modport master (
        output clken, rx, rdy_clr,
`ifdef UART_RX_PARITY_EN
        input  parity_err,
`endif
        input  data, rdy, frame_err, overrun
    );

    modport slave (
        input  clken, rx, rdy_clr,
`ifdef UART_RX_PARITY_EN
        output parity_err,
`endif
        output data, rdy, frame_err, overrun
    );
endinterface

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver with sticky ready, framing and overrun flags.
// Optional even parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic     clk_50m,
    input  logic     rst,
    uart_rx_if.slave bus
);
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_ONE  = SW'(1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] B_ONE  = BW'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t               state_q, state_d;
    logic [SW-1:0]        sample_q, sample_d;
    logic [BW-1:0]        bitpos_q, bitpos_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 rdy_q, rdy_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 armed_q, armed_d;
    logic                 rx_q1, rx_q2;
    logic                 rx_s;
`ifdef UART_RX_PARITY_EN
    logic                 par_q, par_d;
    logic                 perr_q, perr_d;
`endif

    // Two-flop synchroniser; reset high so a reset never looks like a start edge.
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            rx_q1 <= 1'b1;
            rx_q2 <= 1'b1;
        end else begin
            rx_q1 <= bus.rx;
            rx_q2 <= rx_q1;
        end
    end
    assign rx_s = rx_q2;

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sample_q <= '0;
            bitpos_q <= '0;
            shreg_q  <= '0;
            data_q   <= '0;
            rdy_q    <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
            armed_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q    <= 1'b0;
            perr_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            sample_q <= sample_d;
            bitpos_q <= bitpos_d;
            shreg_q  <= shreg_d;
            data_q   <= data_d;
            rdy_q    <= rdy_d;
            ferr_q   <= ferr_d;
            ovr_q    <= ovr_d;
            armed_q  <= armed_d;
`ifdef UART_RX_PARITY_EN
            par_q    <= par_d;
            perr_q   <= perr_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        sample_d = sample_q;
        bitpos_d = bitpos_q;
        shreg_d  = shreg_q;
        data_d   = data_q;
        rdy_d    = rdy_q;
        ferr_d   = ferr_q;
        ovr_d    = ovr_q;
        armed_d  = armed_q;
`ifdef UART_RX_PARITY_EN
        par_d    = par_q;
        perr_d   = perr_q;
`endif
        // Acknowledge acts on any cycle; a byte completing below overrides it.
        if (bus.rdy_clr) begin
            rdy_d = 1'b0;
            ovr_d = 1'b0;
        end
        if (bus.clken) begin
            case (state_q)
                IDLE: begin
                    // A start needs a high level seen first, so a held break is not re-read.
                    if (rx_s) begin
                        armed_d = 1'b1;
                    end else if (armed_q) begin
                        state_d  = START;
                        sample_d = '0;
                        armed_d  = 1'b0;
                    end
                end
                START: begin
                    if (sample_q == S_MID) begin
                        if (!rx_s) begin
                            state_d  = DATA;
                            sample_d = '0;
                            bitpos_d = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        sample_d = sample_q + S_ONE;
                    end
                end
                DATA: begin
                    if (sample_q == S_LAST) begin
                        shreg_d  = {rx_s, shreg_q[DATA_BITS-1:1]};
                        sample_d = '0;
                        if (bitpos_q == B_LAST) begin
                            bitpos_d = '0;
`ifdef UART_RX_PARITY_EN
                            state_d  = PARITY;
`else
                            state_d  = STOP;
`endif
                        end else begin
                            bitpos_d = bitpos_q + B_ONE;
                        end
                    end else begin
                        sample_d = sample_q + S_ONE;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (sample_q == S_LAST) begin
                        par_d    = rx_s;
                        sample_d = '0;
                        state_d  = STOP;
                    end else begin
                        sample_d = sample_q + S_ONE;
                    end
                end
`endif
                STOP: begin
                    if (sample_q == S_LAST) begin
                        sample_d = '0;
                        state_d  = IDLE;
                        if (rx_s) begin
                            data_d = shreg_q;
                            rdy_d  = 1'b1;
                            ferr_d = 1'b0;
                            if (rdy_q && !bus.rdy_clr) ovr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                            perr_d = par_q ^ (^shreg_q);
`endif
                        end else begin
                            ferr_d = 1'b1;
                        end
                    end else begin
                        sample_d = sample_q + S_ONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.data      = data_q;
    assign bus.rdy       = rdy_q;
    assign bus.frame_err = ferr_q;
    assign bus.overrun   = ovr_q;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = perr_q;
`endif
endmodule
